// File: rtl/ro_sensor_hub.sv
// rtl/ro_sensor_hub.sv - multi-channel ring-oscillator measurement controller with UART command port
module ro_sensor_hub #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1000,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] ro_in,
  output logic [N_CH-1:0] osc_en,
  input  logic [7:0]      cmd_data,
  input  logic            cmd_valid,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_busy,
  output logic            busy,
  output logic [N_CH-1:0] done
);

  localparam int ACC_W   = CNT_W + AVG_LOG2;
  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [4:0]       AVG_LAST = 5'((1 << AVG_LOG2) - 1);
  localparam logic [4:0]       NCH5     = 5'(N_CH);

  typedef enum logic [1:0] {M_IDLE, M_SETTLE, M_GATE, M_STORE} m_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_e;

  m_state_e          m_state_q, m_state_d;
  tx_state_e         tx_state_q, tx_state_d;
  logic [N_CH-1:0]   ro_s1_q, ro_s1_d, ro_s2_q, ro_s2_d, ro_s3_q, ro_s3_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [4:0]        avg_q, avg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]        ch_q, ch_d;
  logic [CNT_W-1:0]  res_q [N_CH];
  logic [CNT_W-1:0]  res_d [N_CH];
  logic [N_CH-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        tx_buf_q, tx_buf_d;
  logic              tx_more_q, tx_more_d;
  logic              tx_ign_q, tx_ign_d;

  logic [N_CH-1:0]   ro_rise;
  logic              edge_hit;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_ch;
  logic              ch_ok, tx_free;
  logic              acc_meas, acc_read, acc_stat, acc_clr, cmd_rej;
  logic [15:0]       rd_val;
  logic [7:0]        status_byte;
  logic              unused_cmd_bits;

  assign busy     = (m_state_q != M_IDLE);
  assign osc_en   = busy ? (N_CH'(1) << ch_q) : '0;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign ro_rise  = ro_s2_q & ~ro_s3_q;
  assign edge_hit = |(ro_rise & osc_en);
  assign cnt_inc  = (edge_hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  assign cmd_op          = cmd_data[7:6];
  assign cmd_ch          = cmd_data[3:0];
  assign unused_cmd_bits = ^cmd_data[5:4];
  assign ch_ok           = ({1'b0, cmd_ch} < NCH5);
  assign tx_free         = (tx_state_q == TX_IDLE);
  assign acc_meas        = cmd_valid && tx_free && (cmd_op == 2'b00) && !busy && ch_ok;
  assign acc_read        = cmd_valid && tx_free && (cmd_op == 2'b01) && ch_ok;
  assign acc_stat        = cmd_valid && tx_free && (cmd_op == 2'b10);
  assign acc_clr         = cmd_valid && tx_free && (cmd_op == 2'b11) && !busy;
  assign cmd_rej         = cmd_valid && !(acc_meas || acc_read || acc_stat || acc_clr);
  assign status_byte     = {busy, err_q, 2'b00, ch_q};

  // Synchronizer chain for the asynchronous oscillator inputs; third stage feeds the edge detector
  always_comb begin
    ro_s1_d = ro_in;
    ro_s2_d = ro_s1_q;
    ro_s3_d = ro_s2_q;
  end

  // Select the stored result for a READ, zero-extended to two bytes
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_ch == 4'(i)) rd_val = 16'(res_q[i]);
    end
  end

  // Measurement FSM: settle, gated counting with averaging, result store, plus done/err bookkeeping
  always_comb begin
    m_state_d = m_state_q;
    ch_d      = ch_q;
    tmr_d     = tmr_q;
    avg_d     = avg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    done_d    = done_q;
    err_d     = err_q;
    case (m_state_q)
      M_IDLE: begin
        if (acc_meas) begin
          m_state_d = M_SETTLE;
          ch_d      = cmd_ch;
          tmr_d     = '0;
          avg_d     = '0;
          cnt_d     = '0;
          acc_d     = '0;
        end
      end
      M_SETTLE: begin
        if (tmr_q == SET_LAST) begin
          m_state_d = M_GATE;
          tmr_d     = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      M_GATE: begin
        if (tmr_q == WIN_LAST) begin
          acc_d = acc_q + ACC_W'(cnt_inc);
          cnt_d = '0;
          tmr_d = '0;
          if (avg_q == AVG_LAST) m_state_d = M_STORE;
          else                   avg_d     = avg_q + 5'd1;
        end else begin
          cnt_d = cnt_inc;
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      M_STORE: begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch_q == 4'(i)) begin
            res_d[i]  = CNT_W'(acc_q >> AVG_LOG2);
            done_d[i] = 1'b1;
          end
        end
        m_state_d = M_IDLE;
      end
      default: m_state_d = M_IDLE;
    endcase
    if (acc_clr) begin
      done_d = '0;
      err_d  = 1'b0;
    end
    if (cmd_rej) err_d = 1'b1;
  end

  // Reply engine: latch the reply at acceptance, then hand bytes to the UART one handshake at a time
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_buf_d   = tx_buf_q;
    tx_more_d  = tx_more_q;
    tx_ign_d   = tx_ign_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (acc_read) begin
          tx_data_d  = rd_val[7:0];
          tx_buf_d   = rd_val[15:8];
          tx_more_d  = 1'b1;
          tx_state_d = TX_SEND;
        end else if (acc_stat) begin
          tx_data_d  = status_byte;
          tx_more_d  = 1'b0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          tx_ign_d   = 1'b1;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // The cycle after tx_start may not yet show the UART busy, so it is skipped
        if (tx_ign_q) begin
          tx_ign_d = 1'b0;
          if (tx_more_q) begin
            tx_data_d  = tx_buf_q;
            tx_more_d  = 1'b0;
            tx_state_d = TX_SEND;
          end
        end else if (!tx_busy) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state_q  <= M_IDLE;
      tx_state_q <= TX_IDLE;
      ro_s1_q    <= '0;
      ro_s2_q    <= '0;
      ro_s3_q    <= '0;
      tmr_q      <= '0;
      avg_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ch_q       <= '0;
      for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_buf_q   <= '0;
      tx_more_q  <= 1'b0;
      tx_ign_q   <= 1'b0;
    end else begin
      m_state_q  <= m_state_d;
      tx_state_q <= tx_state_d;
      ro_s1_q    <= ro_s1_d;
      ro_s2_q    <= ro_s2_d;
      ro_s3_q    <= ro_s3_d;
      tmr_q      <= tmr_d;
      avg_q      <= avg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ch_q       <= ch_d;
      res_q      <= res_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_buf_q   <= tx_buf_d;
      tx_more_q  <= tx_more_d;
      tx_ign_q   <= tx_ign_d;
    end
  end

endmodule

// File: tb/tb_ro_sensor_hub.sv
// tb/tb_ro_sensor_hub.sv - directed self-checking bench for ro_sensor_hub
module tb_ro_sensor_hub;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ro_in, osc_en, done;
  logic [7:0] cmd_data, tx_data;
  logic       cmd_valid, tx_start, tx_busy, busy;

  logic [3:0] s_ro_in, s_osc_en, s_done;
  logic [7:0] s_cmd_data, s_tx_data;
  logic       s_cmd_valid, s_tx_start, s_tx_busy, s_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ph    = 0;
  int t0, te, tk, n;

  logic [7:0] txq[$];
  int         txc[$];
  logic [7:0] s_txq[$];

  ro_sensor_hub #(.N_CH(4), .CNT_W(16), .WINDOW(100), .AVG_LOG2(2), .SETTLE_CYC(8)) u_dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .osc_en(osc_en),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  ro_sensor_hub #(.N_CH(4), .CNT_W(9), .WINDOW(4000), .AVG_LOG2(0), .SETTLE_CYC(8)) u_sat (
    .clk(clk), .reset(reset), .ro_in(s_ro_in), .osc_en(s_osc_en),
    .cmd_data(s_cmd_data), .cmd_valid(s_cmd_valid), .tx_data(s_tx_data), .tx_start(s_tx_start),
    .tx_busy(s_tx_busy), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= ph + 1;
  end

  // Oscillators with distinct periods so a gating error changes the count
  assign ro_in[0]   = ((ph % 4) < 2);
  assign ro_in[1]   = ((ph % 10) < 5);
  assign ro_in[2]   = ((ph % 6) < 3);
  assign ro_in[3]   = ((ph % 8) < 4);
  assign s_ro_in    = {3'b000, ((ph % 4) < 2)};

  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      txc.push_back(cyc);
    end
    if (s_tx_start) s_txq.push_back(s_tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b);
    s_cmd_data  = b;
    s_cmd_valid = 1'b1;
    step();
    s_cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; tx_busy = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_data = 8'h00; s_tx_busy = 1'b0;
    repeat (3) step();
    chk("rst_osc_en", osc_en, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    reset = 1'b1;
    repeat (2) step();

    // MEASURE ch1, rejected second MEASURE, STATUS mid-measurement
    send(8'h01);
    t0 = cyc;
    chk("meas_osc_en", osc_en, 4'b0010);
    chk("meas_busy", busy, 1'b1);
    repeat (20) step();
    send(8'h02);
    chk("rej_meas_osc_en", osc_en, 4'b0010);
    repeat (3) step();
    txq.delete(); txc.delete();
    send(8'h80);
    te = cyc;
    repeat (6) step();
    chk("stat_mid_n", txq.size(), 1);
    chk("stat_mid_byte", txq[0], 8'hC1);
    chk("stat_mid_cyc", txc[0], te);
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("busy_len", cyc - t0, 409);
    chk("meas_done", done, 4'b0010);
    chk("meas_osc_off", osc_en, 4'b0000);

    // READ ch1 with an idle transmitter
    txq.delete(); txc.delete();
    send(8'h41);
    te = cyc;
    repeat (8) step();
    chk("rd_n", txq.size(), 2);
    chk("rd_b0", txq[0], 8'h0A);
    chk("rd_b1", txq[1], 8'h00);
    chk("rd_t0", txc[0], te);
    chk("rd_t1", txc[1], te + 2);

    // CLEAR then STATUS shows err cleared
    send(8'hC0);
    chk("clr_done", done, 4'b0000);
    txq.delete();
    send(8'h80);
    repeat (6) step();
    chk("stat_clr", txq[0], 8'h01);

    // MEASURE of a nonexistent channel
    send(8'h05);
    chk("bad_ch_osc", osc_en, 4'b0000);
    chk("bad_ch_busy", busy, 1'b0);
    repeat (3) step();
    chk("bad_ch_busy2", busy, 1'b0);
    txq.delete();
    send(8'h80);
    repeat (6) step();
    chk("bad_ch_stat", txq[0], 8'h41);

    // Reply throttled by tx_busy, command during reply rejected
    send(8'hC0);
    txq.delete(); txc.delete();
    send(8'h41);
    te = cyc;
    step();
    tx_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        cmd_data  = 8'h80;
        cmd_valid = 1'b1;
      end
      step();
      cmd_valid = 1'b0;
    end
    chk("hold_n", txq.size(), 1);
    tx_busy = 1'b0;
    tk = cyc;
    repeat (10) step();
    chk("hold_n2", txq.size(), 2);
    chk("hold_t0", txc[0], te);
    chk("hold_t1", txc[1], tk);
    chk("hold_b0", txq[0], 8'h0A);
    chk("hold_b1", txq[1], 8'h00);
    txq.delete();
    send(8'h80);
    repeat (6) step();
    chk("hold_stat_n", txq.size(), 1);
    chk("hold_stat", txq[0], 8'h41);

    // Saturating instance
    s_send(8'h00);
    n = 0;
    while (s_busy && n < 5000) begin
      step();
      n++;
    end
    chk("sat_busy", s_busy, 1'b0);
    chk("sat_done", s_done, 4'b0001);
    s_send(8'h40);
    repeat (8) step();
    chk("sat_n", s_txq.size(), 2);
    chk("sat_b0", s_txq[0], 8'hFF);
    chk("sat_b1", s_txq[1], 8'h01);

    // Reset pulsed in the middle of a gate window
    send(8'h01);
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("pre_rst_done", done, 4'b0010);
    send(8'h02);
    repeat (60) step();
    chk("pre_rst_osc", osc_en, 4'b0100);
    reset = 1'b0;
    #1;
    chk("mid_rst_osc", osc_en, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 4'b0000);
    chk("mid_rst_tx_start", tx_start, 1'b0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    step();
    reset = 1'b1;
    step();
    txq.delete();
    send(8'h41);
    repeat (8) step();
    chk("post_rst_n", txq.size(), 2);
    chk("post_rst_b0", txq[0], 8'h00);
    chk("post_rst_b1", txq[1], 8'h00);
    txq.delete();
    send(8'h80);
    repeat (6) step();
    chk("post_rst_stat", txq[0], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
